hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-register pending-write scoreboard for RAW
// stalls, plus flush / PC-redirect sequencing for taken branches from ex.
module hazard_ctrl #(
  parameter int unsigned PEND_W       = 2,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic [4:0]  id_rd_addr_i,
  input  logic        id_reg_wen_i,
  input  logic        wb_wen_i,
  input  logic [4:0]  wb_rd_addr_i,
  input  logic        ex_jump_en_i,
  input  logic [31:0] ex_jump_addr_i,
  output logic        stall_o,
  output logic        flush_o,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        sb_err_o
);

  localparam logic [PEND_W-1:0] PendMax     = '1;
  localparam logic [PEND_W-1:0] PendOne     = PEND_W'(1);
  localparam bit                HasFlushSt  = (FLUSH_CYCLES > 1);
  // Counter value loaded on a redirect; the ex_jump_en cycle itself is the first flush cycle.
  localparam logic [3:0]        FlushReload = HasFlushSt ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q [32];
  logic [PEND_W-1:0] pend_d [32];
  logic              sb_err_q, sb_err_d;
  logic              jump_en_q;
  logic [31:0]       jump_addr_q;

  logic rs1_busy, rs2_busy, raw_hazard, sat_hazard, issue, retire;

  // Entry 0 is held at zero, so x0 never appears busy; address checks make that explicit.
  assign rs1_busy   = (id_rs1_addr_i != 5'd0) && (pend_q[id_rs1_addr_i] != '0);
  assign rs2_busy   = (id_rs2_addr_i != 5'd0) && (pend_q[id_rs2_addr_i] != '0);
  assign raw_hazard = id_valid_i && (rs1_busy || rs2_busy);
  assign sat_hazard = id_valid_i && id_reg_wen_i && (id_rd_addr_i != 5'd0) &&
                      (pend_q[id_rd_addr_i] == PendMax);

  assign flush_o = ex_jump_en_i || (state_q == StFlush);
  assign stall_o = (raw_hazard || sat_hazard) && !flush_o;
  assign issue   = id_valid_i && id_reg_wen_i && !stall_o && !flush_o &&
                   (id_rd_addr_i != 5'd0);
  assign retire  = wb_wen_i && (wb_rd_addr_i != 5'd0);

  assign jump_en_o   = jump_en_q;
  assign jump_addr_o = jump_addr_q;
  assign sb_err_o    = sb_err_q;

  // Scoreboard next state: issue increments, retire decrements, both on one register cancel.
  always_comb begin
    sb_err_d  = sb_err_q;
    pend_d[0] = '0;
    for (int unsigned i = 1; i < 32; i++) begin
      pend_d[i] = pend_q[i];
      if (issue && (id_rd_addr_i == 5'(i)) && !(retire && (wb_rd_addr_i == 5'(i)))) begin
        pend_d[i] = pend_q[i] + PendOne;
      end else if (retire && (wb_rd_addr_i == 5'(i)) &&
                   !(issue && (id_rd_addr_i == 5'(i)))) begin
        if (pend_q[i] != '0) begin
          pend_d[i] = pend_q[i] - PendOne;
        end
      end
      // Retiring a write that was never issued is a pipeline bookkeeping bug.
      if (retire && (wb_rd_addr_i == 5'(i)) && (pend_q[i] == '0)) begin
        sb_err_d = 1'b1;
      end
    end
  end

  // Scoreboard and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) begin
        pend_q[i] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 32; i++) begin
        pend_q[i] <= pend_d[i];
      end
      sb_err_q <= sb_err_d;
    end
  end

  // Flush FSM next state: a new redirect while flushing restarts the window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (ex_jump_en_i && HasFlushSt) begin
          state_d = StFlush;
          cnt_d   = FlushReload;
        end
      end
      StFlush: begin
        if (ex_jump_en_i) begin
          cnt_d = FlushReload;
        end else if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Flush FSM state and flush counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered redirect strobe and target; the target holds between redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jump_en_q   <= 1'b0;
      jump_addr_q <= 32'd0;
    end else begin
      jump_en_q <= ex_jump_en_i;
      if (ex_jump_en_i) begin
        jump_addr_q <= ex_jump_addr_i;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural scoreboard/flush model.
module tb_hazard_ctrl;

  localparam int unsigned PEND_W       = 2;
  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int          PMax         = (1 << PEND_W) - 1;

  logic        clk, rst_n;
  logic        id_valid, id_wen, wb_wen, ex_jump_en;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic [31:0] ex_jump_addr;
  logic        stall_o, flush_o, jump_en_o, sb_err_o;
  logic [31:0] jump_addr_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int          m_pend [32];
  bit          m_err;
  int          m_flush_left;
  bit          m_jen;
  logic [31:0] m_jaddr;

  hazard_ctrl #(
    .PEND_W       (PEND_W),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid_i     (id_valid),
    .id_rs1_addr_i  (rs1),
    .id_rs2_addr_i  (rs2),
    .id_rd_addr_i   (rd),
    .id_reg_wen_i   (id_wen),
    .wb_wen_i       (wb_wen),
    .wb_rd_addr_i   (wb_rd),
    .ex_jump_en_i   (ex_jump_en),
    .ex_jump_addr_i (ex_jump_addr),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .jump_en_o      (jump_en_o),
    .jump_addr_o    (jump_addr_o),
    .sb_err_o       (sb_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_wen = 0; rs1 = 0; rs2 = 0; rd = 0;
    wb_wen = 0; wb_rd = 0; ex_jump_en = 0; ex_jump_addr = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
    m_err = 0; m_flush_left = 0; m_jen = 0; m_jaddr = 0;
  endtask

  task automatic set_id(input bit v, input int a1, input int a2, input int d, input bit w);
    id_valid = v; rs1 = 5'(a1); rs2 = 5'(a2); rd = 5'(d); id_wen = w;
  endtask

  task automatic set_wb(input bit w, input int d);
    wb_wen = w; wb_rd = 5'(d);
  endtask

  // Called at posedge+1 with inputs applied; checks outputs, advances model, steps a clock.
  task automatic cycle(input string tag);
    bit e_flush, e_stall, raw, sat, issue, retire;
    #2;
    e_flush = ex_jump_en || (m_flush_left > 0);
    raw     = id_valid && ((rs1 != 0 && m_pend[rs1] != 0) || (rs2 != 0 && m_pend[rs2] != 0));
    sat     = id_valid && id_wen && rd != 0 && m_pend[rd] == PMax;
    e_stall = (raw || sat) && !e_flush;
    chk({tag, ".stall"},     32'(stall_o),   32'(e_stall));
    chk({tag, ".flush"},     32'(flush_o),   32'(e_flush));
    chk({tag, ".jump_en"},   32'(jump_en_o), 32'(m_jen));
    chk({tag, ".jump_addr"}, jump_addr_o,    m_jaddr);
    chk({tag, ".sb_err"},    32'(sb_err_o),  32'(m_err));
    issue  = id_valid && id_wen && !e_stall && !e_flush && rd != 0;
    retire = wb_wen && wb_rd != 0;
    if (retire && m_pend[wb_rd] == 0) m_err = 1;
    if (issue) m_pend[rd] = m_pend[rd] + 1;
    if (retire) m_pend[wb_rd] = (m_pend[wb_rd] > 0) ? m_pend[wb_rd] - 1 : 0;
    if (ex_jump_en) m_flush_left = FLUSH_CYCLES - 1;
    else if (m_flush_left > 0) m_flush_left = m_flush_left - 1;
    m_jen = ex_jump_en;
    if (ex_jump_en) m_jaddr = ex_jump_addr;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    idle_inputs();
    rst_n = 0;
    #2;
    chk({tag, ".stall"},     32'(stall_o),   32'd0);
    chk({tag, ".flush"},     32'(flush_o),   32'd0);
    chk({tag, ".jump_en"},   32'(jump_en_o), 32'd0);
    chk({tag, ".jump_addr"}, jump_addr_o,    32'd0);
    chk({tag, ".sb_err"},    32'(sb_err_o),  32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1;
    #1;
    do_reset("rst0");

    // RAW on x5: stall until the cycle after its retire
    set_id(1, 0, 0, 5, 1);  cycle("raw.issue");
    set_id(1, 5, 0, 0, 0);  cycle("raw.wait0");
    cycle("raw.wait1");
    set_wb(1, 5);           cycle("raw.retire");
    set_wb(0, 0);
    #1 chk("raw.release", 32'(stall_o), 32'd0);
    cycle("raw.go");
    // rs2 hazard path
    set_id(1, 0, 0, 6, 1);  cycle("rs2.issue");
    set_id(1, 0, 6, 0, 0);
    #1 chk("rs2.stall", 32'(stall_o), 32'd1);
    cycle("rs2.wait");
    set_wb(1, 6);           cycle("rs2.retire");
    set_wb(0, 0);           cycle("rs2.go");

    // x0 is never tracked
    for (int i = 0; i < 4; i++) begin
      set_id(1, 0, 0, 0, 1); cycle("x0.issue");
    end
    set_id(1, 0, 0, 0, 0);   cycle("x0.read");
    set_wb(1, 0);            cycle("x0.retire");
    set_wb(0, 0);            cycle("x0.after");
    chk("x0.no_err", 32'(sb_err_o), 32'd0);

    // Redirect to 0x40 with issue attempts during the flush
    ex_jump_en = 1; ex_jump_addr = 32'h0000_0040;
    set_id(1, 0, 0, 3, 1);  cycle("jmp.c0");
    ex_jump_en = 0; ex_jump_addr = 32'hdead_beef;
    chk("jmp.pulse", 32'(jump_en_o), 32'd1);
    chk("jmp.addr", jump_addr_o, 32'h40);
    cycle("jmp.c1");
    set_id(1, 3, 0, 0, 0);
    #1 chk("jmp.no_issue", 32'(stall_o), 32'd0);
    chk("jmp.flush_done", 32'(flush_o), 32'd0);
    cycle("jmp.c2");
    // Back-to-back redirects: last one wins
    ex_jump_en = 1; ex_jump_addr = 32'h100; cycle("jmp2.a");
    ex_jump_addr = 32'h200;                 cycle("jmp2.b");
    ex_jump_en = 0;                         cycle("jmp2.c");
    chk("jmp2.last_wins", jump_addr_o, 32'h200);
    cycle("jmp2.d");

    // Saturation on x7
    set_id(1, 0, 0, 7, 1);
    for (int i = 0; i < 3; i++) cycle("sat.issue");
    #1 chk("sat.stall", 32'(stall_o), 32'd1);
    cycle("sat.stalled");
    set_id(0, 0, 0, 0, 0); set_wb(1, 7); cycle("sat.ret");
    set_id(1, 0, 0, 7, 1);               cycle("sat.same");
    set_wb(0, 0);                        cycle("sat.refill");
    #1 chk("sat.stall2", 32'(stall_o), 32'd1);
    cycle("sat.stalled2");
    set_id(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      set_wb(1, 7); cycle("sat.drain");
    end
    set_wb(0, 0); cycle("sat.idle");

    // Retire on empty x9 sets a sticky error
    set_wb(1, 9); cycle("err.ret");
    set_wb(0, 0);
    chk("err.set", 32'(sb_err_o), 32'd1);
    set_id(1, 9, 0, 0, 0); cycle("err.hold0");
    cycle("err.hold1");

    // Reset with pend[5]=1 and the FSM in flush
    set_id(1, 0, 0, 5, 1); cycle("mid.issue");
    set_id(0, 0, 0, 0, 0);
    ex_jump_en = 1; ex_jump_addr = 32'h80; cycle("mid.jump");
    do_reset("mid.rst");
    set_id(1, 5, 0, 0, 0);
    #1 chk("mid.x5_free", 32'(stall_o), 32'd0);
    cycle("mid.read");

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset("rnd.rst");
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 7),
             ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : 0,
             $urandom_range(0, 7), $urandom_range(0, 1) != 0);
      set_wb($urandom_range(0, 9) < 4, $urandom_range(0, 7));
      ex_jump_en   = ($urandom_range(0, 11) == 0);
      ex_jump_addr = $urandom;
      cycle("rnd");
    end

    idle_inputs();
    cycle("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
